// File: rtl/key_scan_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_scan_debounce
// Purpose  : Per-key 2-FF sync and tick-based debounce of active-low buttons,
//            producing level, press/release strobes and long-press repeat.
//            Build with KEY_REPEAT_EN defined to include the auto-repeat logic.
// Revision : 1.0 - initial release
// ============================================================================
module key_scan_debounce #(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              tick_1ms
);

  localparam int unsigned c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

  localparam int unsigned c_cnt_span = (DEBOUNCE_MS > LONG_MS) ? DEBOUNCE_MS : LONG_MS;
  localparam int unsigned c_cnt_max  = (REPEAT_MS > c_cnt_span) ? REPEAT_MS : c_cnt_span;
  localparam int unsigned c_cnt_w    = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_top  = c_cnt_w'(c_cnt_max - 1);
  localparam logic [c_cnt_w-1:0] c_deb_last = c_cnt_w'(DEBOUNCE_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [c_cnt_w-1:0] c_long_last = c_cnt_w'(LONG_MS - 1);
  localparam logic [c_cnt_w-1:0] c_reload    = c_cnt_w'(LONG_MS - REPEAT_MS);
`endif

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_pwait = 2'd1;
  localparam logic [1:0] c_st_held  = 2'd2;
  localparam logic [1:0] c_st_rwait = 2'd3;

  logic [c_presc_w-1:0] presc_q, presc_d;
  logic [N_KEYS-1:0]    sync1_q, sync2_q;
  logic                 w_tick;

  assign w_tick   = (presc_q == c_presc_last);
  assign presc_d  = w_tick ? '0 : presc_q + 1'b1;
  assign tick_1ms = w_tick;

  // Sync flops hold the raw active-low level, so reset parks them at "released".
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      presc_q <= presc_d;
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic [1:0]         state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d, w_cnt_inc;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               w_s;
`ifdef KEY_REPEAT_EN
    logic               repeat_q, repeat_d;
`endif

    assign w_s       = ~sync2_q[g];
    assign w_cnt_inc = (cnt_q == c_cnt_top) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_d  = 1'b0;
`endif
      case (state_q)
        c_st_idle: begin
          if (w_s) begin
            state_d = c_st_pwait;
            cnt_d   = '0;
          end
        end
        c_st_pwait: begin
          if (!w_s) begin
            state_d = c_st_idle;
            cnt_d   = '0;
          end else if (w_tick) begin
            if (cnt_q == c_deb_last) begin
              state_d = c_st_held;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end
        end
        c_st_held: begin
          if (!w_s) begin
            state_d = c_st_rwait;
            cnt_d   = '0;
          end
`ifdef KEY_REPEAT_EN
          // After the first repeat, reloading shortens each later period to REPEAT_MS.
          else if (w_tick) begin
            if (cnt_q == c_long_last) begin
              repeat_d = 1'b1;
              cnt_d    = c_reload;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end
`endif
        end
        c_st_rwait: begin
          if (w_s) begin
            state_d = c_st_held;
            cnt_d   = '0;
          end else if (w_tick) begin
            if (cnt_q == c_deb_last) begin
              state_d   = c_st_idle;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end
        end
        default: begin
          state_d = c_st_idle;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= c_st_idle;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_q  <= 1'b0;
`endif
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
`ifdef KEY_REPEAT_EN
        repeat_q  <= repeat_d;
`endif
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
`ifdef KEY_REPEAT_EN
    assign key_repeat[g]  = repeat_q;
`else
    assign key_repeat[g]  = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_key_scan_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scan_debounce
// Purpose  : Self-checking bench: directed vector table, multi-cycle corner
//            sequences and randomized keys against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_scan_debounce;

  localparam int N    = 4;
  localparam int TD   = 10;
  localparam int DEB  = 3;
  localparam int LONG = 10;
  localparam int REP  = 4;
`ifdef KEY_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release, key_repeat;
  logic         tick_1ms;

  always #5 clk = ~clk;

  key_scan_debounce #(
    .N_KEYS(N), .TICK_DIV(TD), .DEBOUNCE_MS(DEB), .LONG_MS(LONG), .REPEAT_MS(REP)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .key_repeat(key_repeat), .tick_1ms(tick_1ms)
  );

  // Behavioural reference: a debounced level flips once the pressed-state
  // disagrees with it for DEB whole ticks; repeats follow the held-tick count.
  logic [N-1:0] m_sy1, m_sy2, m_prev_s, m_lvl, m_run, m_s;
  logic [N-1:0] e_press, e_release, e_repeat;
  int           m_rt [N];
  int           m_ht [N];
  int           m_k;
  logic         m_tick;

  assign m_s    = ~m_sy2;
  assign m_tick = ((m_k % TD) == TD - 1);

  always @(posedge clk) begin
    if (rst) begin
      m_sy1 <= '1; m_sy2 <= '1; m_prev_s <= '0; m_lvl <= '0; m_run <= '0; m_k <= 0;
      e_press <= '0; e_release <= '0; e_repeat <= '0;
      for (int i = 0; i < N; i++) begin
        m_rt[i] <= 0;
        m_ht[i] <= 0;
      end
    end else begin
      m_sy1 <= key_in; m_sy2 <= m_sy1; m_prev_s <= m_s; m_k <= m_k + 1;
      e_press <= '0; e_release <= '0; e_repeat <= '0;
      for (int i = 0; i < N; i++) begin
        if (m_s[i] != m_lvl[i]) begin
          if (!m_run[i]) begin
            m_run[i] <= 1'b1;
            m_rt[i]  <= 0;
          end else if (m_tick) begin
            if (m_rt[i] + 1 >= DEB) begin
              m_lvl[i]     <= m_s[i];
              m_run[i]     <= 1'b0;
              e_press[i]   <= m_s[i];
              e_release[i] <= ~m_s[i];
            end else begin
              m_rt[i] <= m_rt[i] + 1;
            end
          end
        end else begin
          m_run[i] <= 1'b0;
        end
        if (m_lvl[i] && m_s[i] && m_prev_s[i]) begin
          if (m_tick) begin
            m_ht[i] <= m_ht[i] + 1;
            if (REP_ON != 0 && m_ht[i] + 1 >= LONG && ((m_ht[i] + 1 - LONG) % REP) == 0)
              e_repeat[i] <= 1'b1;
          end
        end else begin
          m_ht[i] <= 0;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int n_press [N];
  int n_rel   [N];
  int n_rep   [N];
  int p_at    [N];

  task automatic step();
    logic [4*N:0] got, exp;
    @(negedge clk);
    if (chk_en) begin
      got = {key_level, key_press, key_release, key_repeat, tick_1ms};
      exp = {m_lvl, e_press, e_release, e_repeat, m_tick};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cycle k=%0d got=%h expected=%h", m_k, got, exp);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (key_press[i] === 1'b1) begin n_press[i]++; p_at[i] = m_k; end
      if (key_release[i] === 1'b1) n_rel[i]++;
      if (key_repeat[i] === 1'b1) n_rep[i]++;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic wait_phase0();
    int guard = 0;
    while ((m_k % TD) != 0 && guard < 2 * TD) begin
      step();
      guard++;
    end
  endtask

  function automatic int strobes_except(input int k);
    int s = 0;
    for (int i = 0; i < N; i++)
      if (i != k) s += n_press[i] + n_rel[i] + n_rep[i];
    return s;
  endfunction

  typedef struct {
    int key;
    int hold;     // ticks pressed
    int glitch;   // tick offset of a one-tick release, 0 = none
    bit bounce;
    int e_press;
    int e_rel;
    int e_rep;
  } vec_t;

  vec_t vecs [8];
  int   rem  [N];

  initial begin
    vecs[0] = '{1, 50, 0, 1'b0, 1, 1, 10 * REP_ON};
    vecs[1] = '{2,  0, 0, 1'b1, 0, 0, 0};
    vecs[2] = '{3, 30, 0, 1'b0, 1, 1, 5 * REP_ON};
    vecs[3] = '{0, 30, 8, 1'b0, 1, 1, 3 * REP_ON};
    vecs[4] = '{2,  2, 0, 1'b0, 0, 0, 0};
    vecs[5] = '{0,  4, 0, 1'b0, 1, 1, 0};
    vecs[6] = '{3, 13, 0, 1'b0, 1, 1, 1 * REP_ON};
    vecs[7] = '{1, 12, 0, 1'b0, 1, 1, 0};
    for (int i = 0; i < N; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; p_at[i] = -1; rem[i] = 0;
    end

    rst    = 1'b1;
    key_in = '1;
    step();
    chk_en = 1'b1;
    step();
    chk("reset_state", int'({key_level, key_press, key_release, key_repeat, tick_1ms}), 0);
    rst = 1'b0;
    repeat (5) step();

    for (int v = 0; v < 8; v++) begin
      int k, bp, br, bt, bo;
      k = vecs[v].key;
      wait_phase0();
      bp = n_press[k]; br = n_rel[k]; bt = n_rep[k]; bo = strobes_except(k);
      if (vecs[v].bounce) begin
        for (int j = 0; j < 100; j++) begin
          key_in[k] = ((j / 7) % 2 == 0) ? 1'b0 : 1'b1;
          step();
        end
      end else begin
        key_in[k] = 1'b0;
        if (vecs[v].glitch != 0) begin
          repeat (TD * vecs[v].glitch) step();
          key_in[k] = 1'b1;
          repeat (TD) step();
          key_in[k] = 1'b0;
          repeat (TD * (vecs[v].hold - vecs[v].glitch) - TD) step();
        end else begin
          repeat (TD * vecs[v].hold) step();
        end
      end
      key_in[k] = 1'b1;
      repeat (60) step();
      chk($sformatf("vec%0d_press_k%0d", v, k),   n_press[k] - bp, vecs[v].e_press);
      chk($sformatf("vec%0d_release_k%0d", v, k), n_rel[k] - br,   vecs[v].e_rel);
      chk($sformatf("vec%0d_repeat_k%0d", v, k),  n_rep[k] - bt,   vecs[v].e_rep);
      chk($sformatf("vec%0d_other_keys", v),      strobes_except(k) - bo, 0);
    end

    // Keys 0 and 3 pressed together: strobes must land in the same clk.
    begin
      int c0, b0, b3;
      wait_phase0();
      c0 = m_k; b0 = n_press[0]; b3 = n_press[3];
      key_in[0] = 1'b0;
      key_in[3] = 1'b0;
      repeat (40) step();
      chk("simul_press0_count", n_press[0] - b0, 1);
      chk("simul_press3_count", n_press[3] - b3, 1);
      chk("simul_press0_clk", p_at[0], c0 + 3 * TD);
      chk("simul_press3_clk", p_at[3], c0 + 3 * TD);
      key_in[0] = 1'b1;
      key_in[3] = 1'b1;
      repeat (60) step();
    end

    // Reset while key 1 is held: outputs clear, then the press re-qualifies.
    begin
      int n;
      bit found;
      wait_phase0();
      key_in[1] = 1'b0;
      repeat (60) step();
      chk("pre_rst_level1", int'(key_level[1]), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_outputs_zero", int'({key_level, key_press, key_release, key_repeat, tick_1ms}), 0);
      n = 0;
      found = 1'b0;
      while (!found && n < 100) begin
        step();
        n++;
        if (key_press[1] === 1'b1) found = 1'b1;
      end
      chk("rst_repress_delay", n, DEB * TD);
      key_in[1] = 1'b1;
      repeat (60) step();
    end

    // Randomized key activity, short bounces and long holds, occasional reset.
    for (int c = 0; c < 20000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          key_in[i] = ~key_in[i];
          rem[i] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 15))
                                               : int'($urandom_range(20, 400));
        end else begin
          rem[i]--;
        end
      end
      rst = ($urandom_range(0, 3999) == 0) ? 1'b1 : 1'b0;
      step();
    end
    rst    = 1'b0;
    key_in = '1;
    repeat (60) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_scan_debounce.md
Name: key_scan_debounce

Overview:
- Upstream front-end for the clock/alarm/stopwatch top level; replaces the 20 ms-clocked key sampler.
- Runs entirely on the system clock with clock-enable ticks; no derived clocks.
- Per key: synchronises and debounces the raw active-low push-button input, then produces a stable level, one-cycle press/release strobes and a long-press auto-repeat strobe for fast time setting.

Parameters:
- N_KEYS, 4, number of independent key channels.
- TICK_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock).
- DEBOUNCE_MS, 20, ticks an input must stay stable before a level change is accepted.
- LONG_MS, 1000, held ticks after the press strobe before the first repeat strobe.
- REPEAT_MS, 200, ticks between subsequent repeat strobes.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-high.
- key_in  input  N_KEYS  raw buttons, active-low (0 = pressed), asynchronous.
- key_level  output  N_KEYS  debounced state, 1 = pressed.
- key_press  output  N_KEYS  1-clk strobe on accepted press.
- key_release  output  N_KEYS  1-clk strobe on accepted release.
- key_repeat  output  N_KEYS  1-clk auto-repeat strobe while held.
- tick_1ms  output  1  1-clk strobe every TICK_DIV clks, exported for neighbours.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: all outputs 0, prescaler 0, all channels IDLE, counters 0, sync flops 1 (released).
- Prescaler: counts 0..TICK_DIV-1. tick_1ms is high in the clk where the count equals TICK_DIV-1, then the count wraps to 0. It is free-running and shared by all channels.
- Sync: 2-FF synchroniser per key. s = ~key_in after 2 flops, so 1 = pressed. Raw-to-s latency is 2 clks.
- Per-channel FSM, 2-bit state with a tick counter sized for max(DEBOUNCE_MS, LONG_MS).
  - IDLE:
    - s=1 → P_WAIT, cnt=0.
  - P_WAIT:
    - s=0 in any clk → IDLE, cnt=0. This is bounce rejection with no strobe.
    - Otherwise cnt increments on each tick.
    - On the tick where cnt reaches DEBOUNCE_MS-1 with s=1: next clk key_level=1 and key_press=1 for exactly one clk; → HELD, cnt=0.
  - HELD:
    - s=0 → R_WAIT, cnt=0. The repeat count is discarded.
    - Otherwise cnt increments on each tick.
    - First key_repeat fires on the tick where cnt reaches LONG_MS-1. Each later one fires every REPEAT_MS ticks, with cnt reloaded to LONG_MS-REPEAT_MS after each strobe.
  - R_WAIT:
    - s=1 → HELD, with repeat timing restarting from cnt=0 and no strobe.
    - After DEBOUNCE_MS ticks of s=0: next clk key_level=0 and key_release=1 for one clk; → IDLE.
- Latency: a key_in edge to its strobe takes 2 clks (sync) + DEBOUNCE_MS ticks (± up to 1 tick of phase) + 1 clk.
- Strobe rules:
  - key_press, key_release and key_repeat are mutually exclusive per channel in any clk.
  - key_repeat is never asserted in the same clk as key_press.
- Counters saturate and never wrap. The counter width must hold LONG_MS-1.
- Simultaneous keys: channels are fully independent. Strobes may coincide across channels in the same clk.
- Reset mid-operation: a channel in any state returns to IDLE with no strobe emitted. A key held through reset re-qualifies, producing key_press DEBOUNCE_MS ticks after rst deasserts.

Optional Feature:
- KEY_REPEAT_EN defined: auto-repeat logic as above.
- Not defined: key_repeat tied to 0. The HELD counter and repeat compare are removed. HELD exits only to R_WAIT.

Test Plan (sim params TICK_DIV=10, DEBOUNCE_MS=3, LONG_MS=10, REPEAT_MS=4):
- Clean press of key_in[1] held 50 ticks then released → exactly one key_press[1]. key_level[1] rises about 32 clks after the edge. One key_release[1] occurs after release, with no other strobes.
- Bounce: key_in[2] toggles every 7 clks for 100 clks, then settles high (released) → no key_press[2] and no key_level[2] change.
- Long hold of key_in[3] for 30 ticks with KEY_REPEAT_EN → key_repeat[3] at held ticks 10, 14, 18, 22, 26. Without the macro → no key_repeat.
- 1-tick release glitch during HELD → key_level stays 1, no key_release, and the repeat schedule restarts.
- key_in[0] and key_in[3] pressed in the same clk → key_press[0] and key_press[3] asserted in the same clk.
- rst pulsed while key_in[1] is held in HELD → all outputs 0 next clk. key_press[1] re-fires 3 ticks after rst deasserts.
